// File: rtl/eth_frame_script_compare_if.sv
// AXI-Stream style byte bus into and out of the script comparator.
interface eth_frame_script_compare_if #(
  parameter int unsigned C_NUM_SCRIPTS = 4
);
  logic [7:0]               s_axis_tdata;
  logic                     s_axis_tlast;
  logic                     s_axis_tvalid;
  logic [32*C_NUM_SCRIPTS:0] s_axis_tuser;

  logic [7:0]               m_axis_tdata;
  logic                     m_axis_tlast;
  logic                     m_axis_tvalid;
  logic [17*C_NUM_SCRIPTS:0] m_axis_tuser;

  modport master (
    output s_axis_tdata, s_axis_tlast, s_axis_tvalid, s_axis_tuser,
    input  m_axis_tdata, m_axis_tlast, m_axis_tvalid, m_axis_tuser
  );

  modport slave (
    input  s_axis_tdata, s_axis_tlast, s_axis_tvalid, s_axis_tuser,
    output m_axis_tdata, m_axis_tlast, m_axis_tvalid, m_axis_tuser
  );
endinterface

// File: rtl/eth_frame_script_compare.sv
// Per-script field extraction and comparison on a byte stream; beats pass through
// with fixed 2-cycle latency, annotated with per-script match flags and counters.
module eth_frame_script_compare #(
  parameter int unsigned C_NUM_SCRIPTS = 4,
  parameter int unsigned C_MAX_BYTES   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [C_NUM_SCRIPTS-1:0]   script_en,
  input  logic [C_NUM_SCRIPTS-1:0]   clr_counts,
  eth_frame_script_compare_if.slave  axis,
  output logic [32*C_NUM_SCRIPTS-1:0] match_count
);
  localparam int unsigned NS = C_NUM_SCRIPTS;
  localparam int unsigned FW = 8 * C_MAX_BYTES;
  localparam int unsigned AW = FW + 1;
  localparam int unsigned CW = $clog2(C_MAX_BYTES + 1);

  typedef logic [AW-1:0] acc_t;

  // Accumulator MSB is a single extension bit taken from the most significant
  // byte received; BE fields are right-aligned, LE fields left-aligned.
  function automatic acc_t load_byte(input acc_t cur, input logic first, input logic be,
                                     input logic sgn, input logic [CW-1:0] nbytes,
                                     input logic [7:0] b);
    logic [FW-1:0] body;
    logic          sb;
    body = first ? '0 : cur[FW-1:0];
    if (be) begin
      body      = body << 8;
      body[7:0] = b;
    end else begin
      body           = body >> 8;
      body[FW-1 -: 8] = b;
    end
    sb = body[FW-1];
    if (be) begin
      for (int unsigned j = 0; j < C_MAX_BYTES; j++) begin
        if (nbytes == CW'(j + 1)) sb = body[8*j+7];
      end
    end
    return {sgn & sb, body};
  endfunction

  function automatic logic op_pass(input logic [3:0] op, input acc_t d, input acc_t p);
    logic signed [AW-1:0] sd;
    logic signed [AW-1:0] sp;
    sd = d;
    sp = p;
    case (op)
      4'd0:    op_pass = (sd == sp);
      4'd1:    op_pass = (sd > sp);
      4'd2:    op_pass = (sd < sp);
      4'd3:    op_pass = (sd >= sp);
      4'd4:    op_pass = (sd <= sp);
      4'd5:    op_pass = ((d & p) != '0);
      4'd6:    op_pass = ((d & p) == p);
      4'd7:    op_pass = (sd != sp);
      4'd15:   op_pass = 1'b0;
      default: op_pass = 1'b1;
    endcase
  endfunction

  logic          s1_valid, s1_last, s1_fcs;
  logic [7:0]    s1_data;
  logic [NS-1:0] s1_en, s1_eval;
  logic [3:0]    s1_op [NS];
  logic [7:0]    s1_pb [NS];
  logic [7:0]    s1_ib [NS];
  logic [7:0]    out_pb [NS];
  logic [7:0]    out_ib [NS];
  logic          out_fcs;
  logic [NS-1:0] matched;
  acc_t          acc_d [NS];
  acc_t          acc_p [NS];
  logic [CW-1:0] cnt [NS];
  logic [31:0]   mc [NS];

  logic [7:0]    ia [NS];
  logic [7:0]    ib_in [NS];
  logic [7:0]    pa [NS];
  logic [7:0]    pb_in [NS];
  logic [CW-1:0] nb [NS];
  acc_t          nxt_d [NS];
  acc_t          nxt_p [NS];
  logic [NS-1:0] pass;
  logic          frame_end;

  assign frame_end = axis.m_axis_tvalid && axis.m_axis_tlast;

  always_comb begin
    pass = '0;
    for (int unsigned i = 0; i < NS; i++) begin
      ia[i]    = axis.s_axis_tuser[32*i+1  +: 8];
      ib_in[i] = axis.s_axis_tuser[32*i+9  +: 8];
      pa[i]    = axis.s_axis_tuser[32*i+17 +: 8];
      pb_in[i] = axis.s_axis_tuser[32*i+25 +: 8];
      nb[i]    = (cnt[i] == CW'(C_MAX_BYTES)) ? cnt[i] : cnt[i] + CW'(1);
      nxt_d[i] = load_byte(acc_d[i], cnt[i] == '0, ia[i][2], ia[i][3], nb[i], axis.s_axis_tdata);
      nxt_p[i] = load_byte(acc_p[i], cnt[i] == '0, ia[i][2], ia[i][3], nb[i], pa[i]);
      pass[i]  = op_pass(s1_op[i], acc_d[i], acc_p[i]);
    end
  end

  always_comb begin
    axis.m_axis_tuser    = '0;
    axis.m_axis_tuser[0] = out_fcs;
    match_count          = '0;
    for (int unsigned i = 0; i < NS; i++) begin
      axis.m_axis_tuser[17*i+1 +: 17] = {out_pb[i], out_ib[i], matched[i]};
      match_count[32*i +: 32]         = mc[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid           <= 1'b0;
      s1_last            <= 1'b0;
      s1_fcs             <= 1'b0;
      s1_data            <= '0;
      s1_en              <= '0;
      s1_eval            <= '0;
      axis.m_axis_tdata  <= '0;
      axis.m_axis_tlast  <= 1'b0;
      axis.m_axis_tvalid <= 1'b0;
      out_fcs            <= 1'b0;
      matched            <= '1;
      for (int unsigned i = 0; i < NS; i++) begin
        s1_op[i]  <= '0;
        s1_pb[i]  <= '0;
        s1_ib[i]  <= '0;
        out_pb[i] <= '0;
        out_ib[i] <= '0;
        acc_d[i]  <= '0;
        acc_p[i]  <= '0;
        cnt[i]    <= '0;
        mc[i]     <= '0;
      end
    end else begin
      s1_valid           <= axis.s_axis_tvalid;
      s1_last            <= axis.s_axis_tlast;
      s1_fcs             <= axis.s_axis_tuser[0];
      s1_data            <= axis.s_axis_tdata;
      s1_en              <= script_en;
      axis.m_axis_tdata  <= s1_data;
      axis.m_axis_tlast  <= s1_last;
      axis.m_axis_tvalid <= s1_valid;
      out_fcs            <= s1_fcs;
      for (int unsigned i = 0; i < NS; i++) begin
        s1_eval[i] <= ia[i][1];
        s1_op[i]   <= ia[i][7:4];
        s1_pb[i]   <= pb_in[i];
        s1_ib[i]   <= ib_in[i];
        out_pb[i]  <= s1_pb[i];
        out_ib[i]  <= s1_ib[i];

        // A push from the next frame's first beat already starts from zero,
        // so it takes priority over the post-tlast clear.
        if (axis.s_axis_tvalid && ia[i][0]) begin
          acc_d[i] <= nxt_d[i];
          acc_p[i] <= nxt_p[i];
        end else if (s1_valid && s1_last) begin
          acc_d[i] <= '0;
          acc_p[i] <= '0;
        end

        if (axis.s_axis_tvalid) begin
          if (ia[i][1] || axis.s_axis_tlast) cnt[i] <= '0;
          else if (ia[i][0])                 cnt[i] <= nb[i];
        end

        if (s1_valid && (!s1_en[i] || (s1_eval[i] && !pass[i]))) matched[i] <= 1'b0;
        else if (frame_end)                                       matched[i] <= 1'b1;

        if (clr_counts[i])
          mc[i] <= '0;
        else if (frame_end && matched[i] && !out_fcs && (mc[i] != '1))
          mc[i] <= mc[i] + 32'd1;
      end
    end
  end
endmodule
